rv_wb_timer: RTL and testbench
==============================

# rv_wb_timer

Wishbone classic responder giving the core a RISC-V machine timer (64-bit `mtime`/`mtimecmp`) and a level timer interrupt. It sits on the core's data-side Wishbone bus, behind the address decoder, as the responder for the core's memory-stage initiator.

## Interface
- `MTIMECMP_RESET`, default 64'hFFFF_FFFF_FFFF_FFFF: reset value of `mtimecmp`.
- `i_clk`, in, 1: single clock; all state on its rising edge.
- `i_reset_n`, in, 1: asynchronous, active-low reset.
- `i_wb_adr`, in, 32: byte address; only bits [4:2] are decoded.
- `i_wb_dat`, in, 32: write data.
- `o_wb_dat`, out, 32: read data, valid while `o_wb_ack`=1.
- `i_wb_we`, in, 1: 1=write, 0=read.
- `i_wb_sel`, in, 4: byte enables for writes.
- `i_wb_stb`, in, 1: strobe.
- `i_wb_cyc`, in, 1: cycle valid.
- `o_wb_ack`, out, 1: one-cycle acknowledge.
- `o_irq`, out, 1: machine timer interrupt, level.

## Operation
- Register map (offset: name, access):
  - 0x00: MTIME_LO, RW.
  - 0x04: MTIME_HI, RW.
  - 0x08: MTIMECMP_LO, RW.
  - 0x0C: MTIMECMP_HI, RW.
  - 0x10: CTRL, RW. Bit0 = EN (count enable), bit1 = IE (irq enable). Other bits read 0.
  - 0x14: STATUS, RO. Bit0 = PEND (`mtime >= mtimecmp`, unsigned 64-bit).
  - 0x18: PRESC, RW, bits[7:0]. Present only with the macro; otherwise reads 0.
  - 0x1C: reads 0.
- Request: `req = i_wb_cyc & i_wb_stb & ~o_wb_ack`.
- Writes are byte-masked by `i_wb_sel`. Writes to RO or unmapped offsets are acked and ignored.
- Atomic 64-bit read: a read of MTIME_LO copies `mtime[63:32]` into a shadow register in the same cycle. A read of MTIME_HI returns the shadow, not the live value.
- Counting: when EN=1, `mtime` increments by 1 (64-bit, wraps 2^64-1 -> 0) on every tick. Without the macro a tick occurs every cycle.
- Write/count collision: in a cycle where a write to MTIME_LO or MTIME_HI is accepted, the write wins over the increment for the whole 64-bit counter (no increment, no carry that cycle).
- Interrupt: `o_irq` is registered from `PEND & IE`, where PEND is computed from the values of the current cycle. Software clears it by writing a larger `mtimecmp` or by clearing IE.

## Timing
- Reset values:
  - `mtime` = 0; shadow = 0.
  - `mtimecmp` = MTIMECMP_RESET.
  - CTRL = 0; PRESC = 0.
  - `o_wb_ack` = 0; `o_wb_dat` = 0; `o_irq` = 0.
- Ack: registered, `o_wb_ack <= req`. It is 1 exactly one cycle after the request and is never held two cycles.
- Held strobe: a strobe held continuously yields one access every 2 cycles.
- Read data: registered, captured in the request cycle, and driven 0 whenever `o_wb_ack`=0.
- Write effect: a register written in cycle N shows its new value in cycle N+1.
- IRQ latency: `o_irq` rises 1 cycle after `mtime` first reaches `mtimecmp`.
- Reset mid-access: everything returns to reset values immediately and no ack is issued; a dropped `cyc` simply ends the access.

## Configuration
- Macro: `RV_TIMER_PRESC_EN`.
- Defined:
  - PRESC register exists.
  - An 8-bit divide counter produces a tick every PRESC+1 cycles while EN=1.
  - The divide counter resets to 0 when PRESC is written or EN=0.
- Undefined: PRESC reads 0, and a tick occurs every cycle while EN=1.

## Structure
- Shared package `rv_timer_pkg` holds:
  - register offset constants (`TMR_MTIME_LO`…`TMR_PRESC`);
  - CTRL bit indices;
  - `MTIMECMP` default.
- The core's address-map defines gain a timer slave-select value alongside the TCM one.
- Sub-module `rv_timer_presc`: holds the divide counter and outputs the tick (tied to 1 when the macro is off).
- The top module holds the bus FSM, registers and compare.

## Test plan
- Reset, then read all 8 offsets -> MTIME=0, MTIMECMP_LO/HI=0xFFFFFFFF, CTRL=0, STATUS=0; each ack one cycle after `stb`.
- Write CTRL=1, wait 10 cycles, read MTIME_LO -> value 10±2 (exact per bench timing); `stb` held 4 cycles gives exactly 2 acks.
- Write MTIME_LO=0xFFFFFFFE, MTIME_HI=0, CTRL=1; read LO then HI across the rollover -> HI from shadow, consistent 64-bit value.
- Write `sel`=4'b0010 data 0xAABBCCDD to MTIMECMP_LO -> reads 0xFFFFCCFF.
- MTIMECMP=20, CTRL=3 -> `o_irq` rises 1 cycle after MTIME==20. Write MTIMECMP_LO=100 -> `o_irq` falls the next cycle.
- With `RV_TIMER_PRESC_EN`: PRESC=3, EN=1 for 40 cycles -> MTIME=10; assert `i_reset_n`=0 mid-count -> MTIME=0, PRESC=0 asynchronously.

Source files
------------

// File: rtl/rv_timer_pkg.sv
// Shared constants for the RISC-V machine timer: register offsets (word index
// of adr[4:2]), CTRL bit positions, the mtimecmp reset default, data-bus
// slave-select codes, and the byte-lane merge helper.
package rv_timer_pkg;

   localparam logic [2:0] TMR_MTIME_LO    = 3'd0;
   localparam logic [2:0] TMR_MTIME_HI    = 3'd1;
   localparam logic [2:0] TMR_MTIMECMP_LO = 3'd2;
   localparam logic [2:0] TMR_MTIMECMP_HI = 3'd3;
   localparam logic [2:0] TMR_CTRL        = 3'd4;
   localparam logic [2:0] TMR_STATUS      = 3'd5;
   localparam logic [2:0] TMR_PRESC       = 3'd6;

   localparam int CTRL_EN = 0;
   localparam int CTRL_IE = 1;

   localparam logic [63:0] MTIMECMP_DEFAULT = 64'hFFFF_FFFF_FFFF_FFFF;

   // data-side address decoder slave selects
   localparam logic [1:0] SLV_SEL_TCM   = 2'd0;
   localparam logic [1:0] SLV_SEL_TIMER = 2'd1;

   typedef enum logic {
      BUS_IDLE = 1'b0,
      BUS_ACK  = 1'b1
   } bus_state_e;

   // replace only the byte lanes enabled in sel
   function automatic logic [31:0] sel_merge(input logic [31:0] cur,
                                             input logic [31:0] wdat,
                                             input logic [3:0]  sel);
      logic [31:0] res;
      res = cur;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) res[8*b +: 8] = wdat[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/rv_wb_timer_if.sv
// Wishbone classic bus between the core's memory-stage initiator and the timer.
interface rv_wb_timer_if;
   logic [31:0] adr;
   logic [31:0] dat_w;
   logic [31:0] dat_r;
   logic        we;
   logic [3:0]  sel;
   logic        stb;
   logic        cyc;
   logic        ack;

   modport master (output adr, dat_w, we, sel, stb, cyc, input dat_r, ack);
   modport slave  (input adr, dat_w, we, sel, stb, cyc, output dat_r, ack);
endinterface

// File: rtl/rv_timer_presc.sv
// Tick generator for mtime. With RV_TIMER_PRESC_EN defined, a down-counter
// reloads from presc at terminal count and ticks every presc+1 cycles;
// otherwise the tick is constant 1.
module rv_timer_presc (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       en,
   input  logic [7:0] presc,
   input  logic       presc_wr,
   output logic       tick
);
`ifdef RV_TIMER_PRESC_EN
   logic [7:0] cnt_q;

   // restart at 0 so the first tick lands on the first enabled cycle
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)            cnt_q <= 8'd0;
      else if (!en || presc_wr)  cnt_q <= 8'd0;
      else if (cnt_q == 8'd0)    cnt_q <= presc;
      else                       cnt_q <= cnt_q - 8'd1;
   end

   assign tick = (cnt_q == 8'd0);
`else
   logic unused_presc;
   assign unused_presc = ^{i_clk, i_reset_n, en, presc, presc_wr};
   assign tick = 1'b1;
`endif
endmodule

// File: rtl/rv_wb_timer.sv
// RISC-V machine timer as a Wishbone classic responder: 64-bit mtime and
// mtimecmp, CTRL/STATUS, a shadowed MTIME_HI for atomic 64-bit reads and a
// registered level interrupt. RV_TIMER_PRESC_EN adds the PRESC tick divider.
//
// state    | meaning
// BUS_IDLE | waiting for a request; read data held at 0
// BUS_ACK  | ack high for one cycle with read data
module rv_wb_timer
   import rv_timer_pkg::*;
#(
   parameter logic [63:0] MTIMECMP_RESET = MTIMECMP_DEFAULT
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   rv_wb_timer_if.slave  wb,
   output logic          o_irq
);
   bus_state_e  state_q;
   logic [31:0] dat_q;
   logic [31:0] rd_mux;
   logic [63:0] mtime_q;
   logic [63:0] mtimecmp_q;
   logic [31:0] shadow_q;
   logic [1:0]  ctrl_q;
   logic [7:0]  presc_q;
   logic [2:0]  offs;
   logic        req, wr_acc, rd_acc, pend, tick, presc_wr;
   logic        unused_adr;

   assign req      = wb.cyc & wb.stb & (state_q == BUS_IDLE);
   assign offs     = wb.adr[4:2];
   assign wr_acc   = req & wb.we;
   assign rd_acc   = req & ~wb.we;
   assign pend     = (mtime_q >= mtimecmp_q);
   assign presc_wr = wr_acc & (offs == TMR_PRESC);
   assign unused_adr = ^{wb.adr[31:5], wb.adr[1:0]};

   assign wb.ack   = (state_q == BUS_ACK);
   assign wb.dat_r = dat_q;

   rv_timer_presc u_presc (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .en        (ctrl_q[CTRL_EN]),
      .presc     (presc_q),
      .presc_wr  (presc_wr),
      .tick      (tick)
   );

   // read data selection from the current-cycle register values
   always_comb begin
      rd_mux = 32'd0;
      case (offs)
         TMR_MTIME_LO:    rd_mux = mtime_q[31:0];
         TMR_MTIME_HI:    rd_mux = shadow_q;
         TMR_MTIMECMP_LO: rd_mux = mtimecmp_q[31:0];
         TMR_MTIMECMP_HI: rd_mux = mtimecmp_q[63:32];
         TMR_CTRL:        rd_mux = {30'd0, ctrl_q};
         TMR_STATUS:      rd_mux = {31'd0, pend};
         TMR_PRESC:       rd_mux = {24'd0, presc_q};
         default:         rd_mux = 32'd0;
      endcase
   end

   // bus FSM: single-cycle ack, data only valid alongside it
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= BUS_IDLE;
         dat_q   <= 32'd0;
      end else begin
         case (state_q)
            BUS_IDLE: begin
               if (req) begin
                  state_q <= BUS_ACK;
                  dat_q   <= wb.we ? 32'd0 : rd_mux;
               end
            end
            BUS_ACK: begin
               state_q <= BUS_IDLE;
               dat_q   <= 32'd0;
            end
            default: begin
               state_q <= BUS_IDLE;
               dat_q   <= 32'd0;
            end
         endcase
      end
   end

   // mtime: a software write to either half blocks the increment for the whole counter
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         mtime_q  <= 64'd0;
         shadow_q <= 32'd0;
      end else begin
         if (rd_acc && offs == TMR_MTIME_LO) shadow_q <= mtime_q[63:32];
         if (wr_acc && offs == TMR_MTIME_LO)
            mtime_q[31:0] <= sel_merge(mtime_q[31:0], wb.dat_w, wb.sel);
         else if (wr_acc && offs == TMR_MTIME_HI)
            mtime_q[63:32] <= sel_merge(mtime_q[63:32], wb.dat_w, wb.sel);
         else if (ctrl_q[CTRL_EN] && tick)
            mtime_q <= mtime_q + 64'd1;
      end
   end

   // compare and control registers
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         mtimecmp_q <= MTIMECMP_RESET;
         ctrl_q     <= 2'd0;
      end else if (wr_acc) begin
         case (offs)
            TMR_MTIMECMP_LO: mtimecmp_q[31:0]  <= sel_merge(mtimecmp_q[31:0], wb.dat_w, wb.sel);
            TMR_MTIMECMP_HI: mtimecmp_q[63:32] <= sel_merge(mtimecmp_q[63:32], wb.dat_w, wb.sel);
            TMR_CTRL:        if (wb.sel[0]) ctrl_q <= wb.dat_w[1:0];
            default:         ;
         endcase
      end
   end

`ifdef RV_TIMER_PRESC_EN
   // tick divisor, low byte only
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)                presc_q <= 8'd0;
      else if (presc_wr && wb.sel[0]) presc_q <= wb.dat_w[7:0];
   end
`else
   assign presc_q = 8'd0;
`endif

   // level interrupt registered from the current-cycle compare
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) o_irq <= 1'b0;
      else            o_irq <= pend & ctrl_q[CTRL_IE];
   end

endmodule

// File: tb/tb_rv_wb_timer.sv
// Directed bench for rv_wb_timer; expected values are hand-derived from the
// access timing of wb_acc (request edge one cycle after drive, 2 cycles/access).
module tb_rv_wb_timer;
   import rv_timer_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   logic irq;
   int   n_checks = 0;
   int   n_errors = 0;

   rv_wb_timer_if bus ();

   rv_wb_timer dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .wb        (bus),
      .o_irq     (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic bus_clear();
      bus.cyc   = 1'b0;
      bus.stb   = 1'b0;
      bus.we    = 1'b0;
      bus.sel   = 4'h0;
      bus.adr   = 32'd0;
      bus.dat_w = 32'd0;
   endtask

   // called 1ns after a rising edge; returns 1ns after the edge following the ack
   task automatic wb_acc(input logic we, input logic [2:0] offs, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdat);
      bus.cyc   = 1'b1;
      bus.stb   = 1'b1;
      bus.we    = we;
      bus.adr   = 32'h4000_0000 | {27'd0, offs, 2'b00};
      bus.dat_w = dat;
      bus.sel   = sel;
      @(posedge clk); #1;
      chk("ack", {63'd0, bus.ack}, 64'd1);
      rdat = bus.dat_r;
      bus_clear();
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [2:0] offs, input logic [31:0] dat, input logic [3:0] sel);
      logic [31:0] d;
      wb_acc(1'b1, offs, dat, sel, d);
   endtask

   task automatic rd(input string tag, input logic [2:0] offs, input logic [31:0] exp);
      logic [31:0] d;
      wb_acc(1'b0, offs, 32'd0, 4'hF, d);
      chk(tag, {32'd0, d}, {32'd0, exp});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int acks;
      bus_clear();
      rst_n = 1'b0;
      #3;
      chk("rst_ack", {63'd0, bus.ack}, 64'd0);
      chk("rst_dat", {32'd0, bus.dat_r}, 64'd0);
      chk("rst_irq", {63'd0, irq}, 64'd0);
      #20 rst_n = 1'b1;
      @(posedge clk); #1;

      // reset values across all offsets
      rd("r_mtlo",  TMR_MTIME_LO,    32'd0);
      rd("r_mthi",  TMR_MTIME_HI,    32'd0);
      rd("r_cmplo", TMR_MTIMECMP_LO, 32'hFFFF_FFFF);
      rd("r_cmphi", TMR_MTIMECMP_HI, 32'hFFFF_FFFF);
      rd("r_ctrl",  TMR_CTRL,        32'd0);
      rd("r_stat",  TMR_STATUS,      32'd0);
      rd("r_presc", TMR_PRESC,       32'd0);
      rd("r_1c",    3'd7,            32'd0);
      chk("dat_idle", {32'd0, bus.dat_r}, 64'd0);

      // free-running count
      wr(TMR_CTRL, 32'd1, 4'hF);
      repeat (9) @(posedge clk);
      #1;
      rd("cnt_lo", TMR_MTIME_LO, 32'd10);
      rd("cnt_hi", TMR_MTIME_HI, 32'd0);

      // held strobe: one access every two cycles
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0;
      bus.adr = {27'd0, TMR_CTRL, 2'b00}; bus.sel = 4'hF;
      acks = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (bus.ack) acks++;
      end
      bus_clear();
      chk("held_acks", 64'(acks), 64'd2);
      @(posedge clk); #1;

      // LO/HI across a 32-bit rollover
      wr(TMR_CTRL, 32'd0, 4'hF);
      wr(TMR_MTIME_LO, 32'hFFFF_FFFE, 4'hF);
      wr(TMR_MTIME_HI, 32'd0, 4'hF);
      wr(TMR_CTRL, 32'd1, 4'hF);
      rd("roll_lo0", TMR_MTIME_LO, 32'hFFFF_FFFF);
      rd("roll_hi0", TMR_MTIME_HI, 32'd0);
      rd("roll_lo1", TMR_MTIME_LO, 32'd3);
      rd("roll_hi1", TMR_MTIME_HI, 32'd1);

      // 64-bit wrap to zero
      wr(TMR_CTRL, 32'd0, 4'hF);
      wr(TMR_MTIME_LO, 32'hFFFF_FFFF, 4'hF);
      wr(TMR_MTIME_HI, 32'hFFFF_FFFF, 4'hF);
      wr(TMR_CTRL, 32'd1, 4'hF);
      rd("wrap_lo", TMR_MTIME_LO, 32'd0);
      rd("wrap_hi", TMR_MTIME_HI, 32'd0);

      // write beats increment in the same cycle
      wr(TMR_MTIME_LO, 32'h100, 4'hF);
      rd("wwin_lo", TMR_MTIME_LO, 32'h101);

      // byte-masked write
      wr(TMR_CTRL, 32'd0, 4'hF);
      wr(TMR_MTIMECMP_LO, 32'hAABB_CCDD, 4'b0010);
      rd("sel_lo", TMR_MTIMECMP_LO, 32'hFFFF_CCFF);
      rd("sel_hi", TMR_MTIMECMP_HI, 32'hFFFF_FFFF);

`ifndef RV_TIMER_PRESC_EN
      wr(TMR_PRESC, 32'hFF, 4'hF);
      rd("presc_off", TMR_PRESC, 32'd0);
`endif

      // interrupt rise latency and clear paths
      wr(TMR_MTIME_LO, 32'd0, 4'hF);
      wr(TMR_MTIME_HI, 32'd0, 4'hF);
      wr(TMR_MTIMECMP_HI, 32'd0, 4'hF);
      wr(TMR_MTIMECMP_LO, 32'd20, 4'hF);
      wr(TMR_CTRL, 32'd3, 4'hF);
      k = 1;
      while (irq !== 1'b1 && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      chk("irq_lat", 64'(k), 64'd21);
      rd("stat_pend", TMR_STATUS, 32'd1);
      wr(TMR_MTIMECMP_LO, 32'd100, 4'hF);
      chk("irq_fall", {63'd0, irq}, 64'd0);
      rd("stat_clr", TMR_STATUS, 32'd0);
      wr(TMR_MTIMECMP_LO, 32'd20, 4'hF);
      chk("irq_again", {63'd0, irq}, 64'd1);
      wr(TMR_CTRL, 32'd1, 4'hF);
      chk("irq_ie0", {63'd0, irq}, 64'd0);
      wr(TMR_CTRL, 32'd3, 4'hF);
      chk("irq_ie1", {63'd0, irq}, 64'd1);

      // reset in the middle of an access
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0;
      bus.adr = {27'd0, TMR_MTIMECMP_LO, 2'b00}; bus.sel = 4'hF;
      #3 rst_n = 1'b0;
      #1;
      chk("mid_ack", {63'd0, bus.ack}, 64'd0);
      chk("mid_irq", {63'd0, irq}, 64'd0);
      chk("mid_dat", {32'd0, bus.dat_r}, 64'd0);
      @(posedge clk); #1;
      chk("mid_ack2", {63'd0, bus.ack}, 64'd0);
      bus_clear();
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      rd("post_ctrl", TMR_CTRL, 32'd0);
      rd("post_mt",   TMR_MTIME_LO, 32'd0);
      rd("post_cmp",  TMR_MTIMECMP_LO, 32'hFFFF_FFFF);

`ifdef RV_TIMER_PRESC_EN
      // divided tick, then asynchronous reset mid-count
      wr(TMR_PRESC, 32'd3, 4'hF);
      rd("presc_rd", TMR_PRESC, 32'd3);
      wr(TMR_CTRL, 32'd1, 4'hF);
      repeat (38) @(posedge clk);
      #1;
      rd("presc_mt", TMR_MTIME_LO, 32'd10);
      #3 rst_n = 1'b0;
      #10 rst_n = 1'b1;
      @(posedge clk); #1;
      rd("presc_rst", TMR_PRESC, 32'd0);
      rd("presc_mt0", TMR_MTIME_LO, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
